// File: rtl/konix_bus_arbiter.sv
// konix_bus_arbiter
// Shares the single memory address bus between the 8088 CPU, the SlipStream
// video fetch and the blitter/DSP byte port. Runs the HOLD/HLDA handshake with
// the CPU and, while the bus is held, grants one access per cycle with video
// ahead of the blitter. Blitter tenures are capped at BLIT_MAX_BURST grants.
// After every tenure the CPU keeps the bus for CPU_WINDOW cycles before the
// blitter may ask again.
module konix_bus_arbiter #(
    parameter int BLIT_MAX_BURST = 16,
    parameter int CPU_WINDOW     = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hlda,
    output logic        hold,
    input  logic [19:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    input  logic        vid_req,
    input  logic [19:0] vid_addr,
    output logic        vid_gnt,
    input  logic        blt_req,
    input  logic        blt_we,
    input  logic [19:0] blt_addr,
    input  logic [7:0]  blt_wdata,
    output logic        blt_gnt,
    output logic [19:0] mem_addr,
    output logic        mem_we,
    output logic        mem_word,
    output logic [7:0]  mem_wdata,
    output logic        ext_owner
);

    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        HOLD_WAIT = 2'd1,
        EXT_OWN   = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(BLIT_MAX_BURST);
    localparam logic [7:0] WIN_MAX   = 8'(CPU_WINDOW);

    state_t     state_q, state_d;
    logic       hold_q, hold_d;
    logic [7:0] win_cnt_q, win_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;

    // The counters stop at their limit and never wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    // State, HOLD and counter registers; reset lands in CPU_OWN even mid-burst.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= CPU_OWN;
            hold_q      <= 1'b0;
            win_cnt_q   <= 8'd0;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            win_cnt_q   <= win_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic, grant decode and the memory bus mux.
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        burst_cnt_d = burst_cnt_q;
        vid_gnt     = 1'b0;
        blt_gnt     = 1'b0;
        mem_addr    = cpu_addr;
        mem_we      = cpu_wr;
        mem_word    = 1'b0;
        mem_wdata   = cpu_wdata;

        case (state_q)
            CPU_OWN: begin
                win_cnt_d = sat_inc(win_cnt_q, WIN_MAX);
                // Video bypasses the CPU window; the blitter has to wait it out.
                if (vid_req) begin
                    state_d = HOLD_WAIT;
                end else if (blt_req && (win_cnt_q == WIN_MAX)) begin
                    state_d = HOLD_WAIT;
                end
            end

            HOLD_WAIT: begin
                if (hlda) begin
                    state_d     = EXT_OWN;
                    burst_cnt_d = 8'd0;
                end else if (!vid_req && !blt_req) begin
                    state_d = CPU_OWN;
                end
            end

            EXT_OWN: begin
                mem_we = 1'b0;
                if (!hlda) begin
                    // The CPU took the bus back without being asked: make no
                    // access and resume as if the tenure had ended cleanly.
                    state_d   = CPU_OWN;
                    win_cnt_d = 8'd0;
                end else if (vid_req) begin
                    vid_gnt  = 1'b1;
                    mem_addr = vid_addr;
                    mem_word = 1'b1;
                end else if (blt_req && (burst_cnt_q < BURST_MAX)) begin
                    blt_gnt     = 1'b1;
                    mem_addr    = blt_addr;
                    mem_we      = blt_we;
                    mem_wdata   = blt_wdata;
                    burst_cnt_d = sat_inc(burst_cnt_q, BURST_MAX);
                end else begin
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (!hlda) begin
                    state_d   = CPU_OWN;
                    win_cnt_d = 8'd0;
                end
            end

            default: begin
                state_d = CPU_OWN;
            end
        endcase

        hold_d = (state_d == HOLD_WAIT) || (state_d == EXT_OWN);
    end

    assign hold      = hold_q;
    assign ext_owner = (state_q == EXT_OWN);

endmodule
